// File: rtl/mips_pkg.sv
// Shared core constants for the MIPS pipeline.
// Register-file geometry and the hardwired zero register index.
package mips_pkg;
  localparam int REG_W    = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage register-file bus: read ports, write-back, issue and scoreboard status.
interface regfile_sb_if
  import mips_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int AW    = REG_AW,
  parameter int NRD   = 2
);
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [AW:0]          pend_cnt;

  modport master (
    output rd_addr, we, wa, wd, iss_en, iss_addr,
    input  rd_data, rd_busy, pend_cnt
  );

  modport slave (
    input  rd_addr, we, wa, wd, iss_en, iss_addr,
    output rd_data, rd_busy, pend_cnt
  );
endinterface

// File: rtl/regfile_sb_rport.sv
// One combinational read port: zero-register masking, write-through bypass,
// then the stored value and its pending bit.
module regfile_sb_rport
  import mips_pkg::*;
#(
  parameter int WIDTH    = REG_W,
  parameter int AW       = REG_AW,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] regs [2**AW],
  input  logic [2**AW-1:0] pending,
  output logic [WIDTH-1:0] data,
  output logic             busy
);
  logic zero_hit_s;
  logic bypass_s;

  // Decode the port address and pick zero, bypassed or stored operand.
  always_comb begin
    zero_hit_s = 1'b0;
    bypass_s   = we && (wa == addr);
    data       = regs[addr];
    busy       = pending[addr];
    if (ZERO_REG != 0) begin
      zero_hit_s = (addr == AW'(REG_ZERO));
    end else begin
      zero_hit_s = 1'b0;
    end
    // A dropped zero-register write never bypasses, so the zero check wins.
    if (zero_hit_s) begin
      data = {WIDTH{1'b0}};
      busy = 1'b0;
    end else if (bypass_s) begin
      data = wd;
      busy = 1'b0;
    end else begin
      data = regs[addr];
      busy = pending[addr];
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass, hardwired zero
// register and a per-register pending-write scoreboard.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int WIDTH    = REG_W,
  parameter int AW       = REG_AW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic             wr_ok_s;
  logic             iss_ok_s;
  logic [AW:0]      cnt_s;
  logic [WIDTH-1:0] rdata_s [NRD];
  logic             rbusy_s [NRD];

  // Drop writes and issues aimed at the hardwired zero register.
  always_comb begin
    wr_ok_s  = bus.we;
    iss_ok_s = bus.iss_en;
    if (ZERO_REG != 0) begin
      wr_ok_s  = bus.we     && (bus.wa       != AW'(REG_ZERO));
      iss_ok_s = bus.iss_en && (bus.iss_addr != AW'(REG_ZERO));
    end else begin
      wr_ok_s  = bus.we;
      iss_ok_s = bus.iss_en;
    end
  end

  // Next pending vector: an issue on the same edge as a write-back is newer and wins.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 0; i < DEPTH; i++) begin
      pend_nxt_s[i] = (iss_ok_s && (bus.iss_addr == AW'(i))) ? 1'b1 :
                      (wr_ok_s  && (bus.wa       == AW'(i))) ? 1'b0 : pend_r[i];
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[bus.wa] <= bus.wd;
    end
  end

  // Pending-write scoreboard with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Population count of the registered pending vector.
  always_comb begin
    cnt_s = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt_s = cnt_s + {{AW{1'b0}}, pend_r[i]};
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rport
    regfile_sb_rport #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rport (
      .addr    (bus.rd_addr[k*AW +: AW]),
      .we      (bus.we),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .regs    (mem_r),
      .pending (pend_r),
      .data    (rdata_s[k]),
      .busy    (rbusy_s[k])
    );
  end

  // Pack per-port results onto the bus.
  always_comb begin
    bus.rd_data = {(NRD*WIDTH){1'b0}};
    bus.rd_busy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*WIDTH +: WIDTH] = rdata_s[k];
      bus.rd_busy[k]                = rbusy_s[k];
    end
    bus.pend_cnt = cnt_s;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios pinned by literals,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_sb;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_sb_if #(.WIDTH(W), .AW(AW), .NRD(N)) bus ();

  regfile_sb #(.WIDTH(W), .AW(AW), .NRD(N), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain arrays of register contents and pending flags.
  logic [W-1:0] m_mem  [32];
  bit           m_pend [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  <= 32'd0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (bus.we && bus.wa != 5'd0) begin
        m_mem[bus.wa]  <= bus.wd;
        m_pend[bus.wa] <= 1'b0;
      end
      if (bus.iss_en && bus.iss_addr != 5'd0) m_pend[bus.iss_addr] <= 1'b1;
    end
  end

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.we && bus.wa == a) return bus.wd;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 5'd0) return 1'b0;
    if (bus.we && bus.wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic lit(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_model();
    logic [AW-1:0] a;
    for (int k = 0; k < N; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      lit($sformatf("model rd_data%0d addr %0d", k, a), longint'(bus.rd_data[k*W +: W]), longint'(exp_data(a)));
      lit($sformatf("model rd_busy%0d addr %0d", k, a), longint'(bus.rd_busy[k]), longint'(exp_busy(a)));
    end
    lit("model pend_cnt", longint'(bus.pend_cnt), longint'(exp_cnt()));
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iss, input logic [4:0] ia,
                       input logic [4:0] a0, input logic [4:0] a1);
    bus.we       = we;
    bus.wa       = wa;
    bus.wd       = wd;
    bus.iss_en   = iss;
    bus.iss_addr = ia;
    bus.rd_addr  = {a1, a0};
  endtask

  // One clock cycle: drive after the edge, check the model at the falling edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic iss, input logic [4:0] ia,
                     input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #1;
    drive(we, wa, wd, iss, ia, a0, a1);
    @(negedge clk);
    compare_model();
  endtask

  function automatic logic [31:0] d0();
    return bus.rd_data[31:0];
  endfunction

  initial begin
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    // Reset held: every address reads zero and not busy.
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i + 1));
      #1;
      lit($sformatf("reset rd_data0 a%0d", i), longint'(bus.rd_data[31:0]), 0);
      lit($sformatf("reset rd_data1 a%0d", i + 1), longint'(bus.rd_data[63:32]), 0);
      lit($sformatf("reset rd_busy a%0d", i), longint'(bus.rd_busy), 0);
    end
    lit("reset pend_cnt", longint'(bus.pend_cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // Write-through bypass then registered value.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    lit("bypass data", longint'(d0()), longint'(32'hDEADBEEF));
    lit("bypass busy", longint'(bus.rd_busy[0]), 0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    lit("stored data r5", longint'(d0()), longint'(32'hDEADBEEF));

    // Scoreboard: issue, observe busy, then write-back clears it.
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    lit("issue same-cycle busy", longint'(bus.rd_busy[0]), 0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    lit("issue busy r7", longint'(bus.rd_busy[0]), 1);
    lit("issue pend_cnt", longint'(bus.pend_cnt), 1);
    cyc(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0);
    lit("wb bypass data r7", longint'(d0()), longint'(32'h12));
    lit("wb bypass busy r7", longint'(bus.rd_busy[0]), 0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    lit("wb pend_cnt", longint'(bus.pend_cnt), 0);

    // Simultaneous issue and write-back to the same register.
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    cyc(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd0);
    lit("simul pend before", longint'(bus.pend_cnt), 1);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    lit("simul data r9", longint'(d0()), longint'(32'h55));
    lit("simul busy r9", longint'(bus.rd_busy[0]), 1);
    lit("simul pend after", longint'(bus.pend_cnt), 1);
    cyc(1'b1, 5'd9, 32'h56, 1'b0, 5'd0, 5'd9, 5'd0);

    // Zero register ignores writes and issues, including on the bypass path.
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    lit("zero bypass data", longint'(d0()), 0);
    lit("zero bypass busy", longint'(bus.rd_busy), 0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    lit("zero data after", longint'(d0()), 0);
    lit("zero pend_cnt", longint'(bus.pend_cnt), 0);
    lit("r9 data", longint'(bus.rd_data[63:32]), longint'(32'h56));

    // Three pending registers with data, then an asynchronous reset pulse.
    cyc(1'b1, 5'd3, 32'hA, 1'b1, 5'd6, 5'd3, 5'd6);
    cyc(1'b1, 5'd4, 32'hB, 1'b1, 5'd3, 5'd3, 5'd4);
    cyc(1'b1, 5'd6, 32'hC, 1'b1, 5'd4, 5'd3, 5'd6);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd6);
    lit("pre-reset pend_cnt", longint'(bus.pend_cnt), 2);
    lit("pre-reset r6 data", longint'(bus.rd_data[63:32]), longint'(32'hC));
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd3, 5'd4);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    lit("pre-reset pend3", longint'(bus.pend_cnt), 3);
    lit("pre-reset busy", longint'(bus.rd_busy), 3);
    lit("pre-reset r3 data", longint'(d0()), longint'(32'hA));
    #1;
    reset = 1'b1;
    #1;
    lit("async data0", longint'(d0()), 0);
    lit("async data1", longint'(bus.rd_data[63:32]), 0);
    lit("async busy", longint'(bus.rd_busy), 0);
    lit("async pend_cnt", longint'(bus.pend_cnt), 0);
    #1;
    reset = 1'b0;

    // Randomized traffic, biased so reads often hit the write or issue address.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      logic [4:0] ia;
      wa = 5'($urandom_range(0, 31));
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), wa, $urandom,
          1'($urandom_range(0, 1)), ia,
          ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 1) == 1) ? ia : 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
